step_clock_ctrl: RTL



---
 rtl/step_clock_ctrl_if.sv | 21 ++
 rtl/step_clock_ctrl.sv | 133 +++++++++++++
 2 files changed

// File: rtl/step_clock_ctrl_if.sv
// Run/step controller bus: operator/CPU inputs and the strobe/debug outputs.
interface step_clock_ctrl_if #(
   parameter int unsigned CNT_W = 32
) ();
   logic             run_sw;
   logic             step_btn;
   logic             halt;
   logic             cpu_en;
   logic [CNT_W-1:0] cycle_count;
   logic [1:0]       state;

   modport master (
      output run_sw, step_btn, halt,
      input  cpu_en, cycle_count, state
   );

   modport slave (
      input  run_sw, step_btn, halt,
      output cpu_en, cycle_count, state
   );
endinterface

// File: rtl/step_clock_ctrl.sv
// Run/single-step controller: produces a one-cycle CPU enable strobe either
// free-running every DIV cycles (RUN) or once per debounced button press (STEP).
module step_clock_ctrl #(
   parameter int unsigned DIV       = 25000000,
   parameter int unsigned DB_CYCLES = 1000000,
   parameter int unsigned CNT_W     = 32
) (
   input  logic              clk,
   input  logic              reset,
   step_clock_ctrl_if.slave  bus
);

   localparam int unsigned DIV_W = $clog2(DIV);
   localparam int unsigned DB_W  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_RUN    = 2'b01,
      S_STEP   = 2'b10,
      S_HALTED = 2'b11
   } state_t;

   logic             run_m, run_s;
   logic             step_m, step_s;
   logic             step_db, step_db_d;
   logic [DB_W-1:0]  db_cnt;
   logic [DIV_W-1:0] div_cnt;
   state_t           state_q;
   logic             cpu_en_q;
   logic [CNT_W-1:0] cycle_count_q;

   logic             div_last;
   logic             tick;
   logic             step_req;

   assign div_last = (div_cnt == DIV_W'(DIV - 1));
   assign tick     = (state_q == S_RUN) && div_last;
   assign step_req = step_db & ~step_db_d;

   assign bus.cpu_en      = cpu_en_q;
   assign bus.cycle_count = cycle_count_q;
   assign bus.state       = state_q;

   // Two-flop synchronisers for the asynchronous operator inputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         run_m  <= 1'b0;
         run_s  <= 1'b0;
         step_m <= 1'b0;
         step_s <= 1'b0;
      end else begin
         run_m  <= bus.run_sw;
         run_s  <= run_m;
         step_m <= bus.step_btn;
         step_s <= step_m;
      end
   end

   // Debounce: accept a new button level only after DB_CYCLES stable cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         db_cnt    <= '0;
         step_db   <= 1'b0;
         step_db_d <= 1'b0;
      end else begin
         step_db_d <= step_db;
         if (step_s == step_db) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
            step_db <= step_s;
            db_cnt  <= '0;
         end else begin
            db_cnt <= db_cnt + DB_W'(1);
         end
      end
   end

   // Controller FSM with divider, strobe and strobe counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         cpu_en_q      <= 1'b0;
         cycle_count_q <= '0;
         div_cnt       <= '0;
      end else begin
         cpu_en_q <= 1'b0;

         // Divider only advances in RUN so every RUN entry starts from zero.
         if (state_q == S_RUN) begin
            div_cnt <= div_last ? '0 : div_cnt + DIV_W'(1);
         end else begin
            div_cnt <= '0;
         end

         if (bus.halt && (state_q != S_HALTED)) begin
            state_q <= S_HALTED;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (run_s) begin
                     state_q <= S_RUN;
                  end else if (step_req) begin
                     state_q       <= S_STEP;
                     cpu_en_q      <= 1'b1;
                     cycle_count_q <= cycle_count_q + CNT_W'(1);
                  end
               end
               S_RUN: begin
                  if (!run_s) begin
                     state_q <= S_IDLE;
                  end else if (tick) begin
                     cpu_en_q      <= 1'b1;
                     cycle_count_q <= cycle_count_q + CNT_W'(1);
                  end
               end
               S_STEP: begin
                  state_q <= S_IDLE;
               end
               S_HALTED: begin
                  // Operator must drop the run switch before leaving halt.
                  if (!bus.halt && !run_s) begin
                     state_q <= S_IDLE;
                  end
               end
               default: begin
                  state_q <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule
